// File: rtl/edge_detect_multi.sv
// edge_detect_multi
//   Multi-channel edge detector for asynchronous level inputs. Each channel
//   has the following stages, in order:
//     1. a SYNC_STAGES-deep synchroniser;
//     2. a glitch filter. The filtered level follows the synchronised input
//        only after FILTER_LEN consecutive disagreeing cycles;
//     3. a registered one-cycle edge pulse. MODE selects the direction:
//        0 = rising, 1 = falling, 2 = both;
//     4. a sticky event flag with per-bit write-1-to-clear.
//
// Ports
//   clk        sole clock; all state updates on posedge
//   rst        asynchronous, active-high reset
//   in         [WIDTH] asynchronous level inputs
//   clr        [WIDTH] synchronous write-1-to-clear for sticky
//   level      [WIDTH] synchronised, filtered level per channel
//   pulse      [WIDTH] one-cycle pulse per qualifying edge
//   sticky     [WIDTH] latched event flag per channel
//   any_event  OR-reduction of sticky

module edge_detect_multi #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 1,
    parameter int unsigned MODE        = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] pulse,
    output logic [WIDTH-1:0] sticky,
    output logic             any_event
);

    localparam int unsigned    CW      = $clog2(FILTER_LEN) + 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER_LEN - 1);

    // Parameter legality is checked at elaboration.
    if (MODE > 2) begin : g_bad_mode
        $error("edge_detect_multi: MODE must be 0, 1 or 2");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("edge_detect_multi: WIDTH must be at least 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("edge_detect_multi: SYNC_STAGES must be at least 2");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter
        $error("edge_detect_multi: FILTER_LEN must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync_q   [WIDTH];
    logic [CW-1:0]          cnt_q    [WIDTH];
    logic [CW-1:0]          cnt_next [WIDTH];
    logic [WIDTH-1:0]       s;
    logic [WIDTH-1:0]       level_next;
    logic [WIDTH-1:0]       pulse_next;
    logic [WIDTH-1:0]       sticky_next;

    // Filter and edge qualification. The counter counts consecutive
    // disagreeing cycles. Any agreeing cycle restarts qualification.
    always_comb begin
        s          = '0;
        level_next = level;
        pulse_next = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            s[i]        = sync_q[i][SYNC_STAGES-1];
            cnt_next[i] = '0;
            if (s[i] != level[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_next[i] = s[i];
                    case (MODE)
                        0:       pulse_next[i] = s[i];
                        1:       pulse_next[i] = ~s[i];
                        2:       pulse_next[i] = 1'b1;
                        default: pulse_next[i] = 1'b0;
                    endcase
                end else begin
                    cnt_next[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        // A new pulse overrides a same-cycle clear.
        sticky_next = pulse_next | (sticky & ~clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                sync_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            level  <= '0;
            pulse  <= '0;
            sticky <= '0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], in[i]};
                cnt_q[i]  <= cnt_next[i];
            end
            level  <= level_next;
            pulse  <= pulse_next;
            sticky <= sticky_next;
        end
    end

    assign any_event = |sticky;

endmodule

// File: tb/tb_edge_detect_multi.sv
// tb_edge_detect_multi
//   Directed testbench for edge_detect_multi. Four instances share the
//   stimulus: defaults, FILTER_LEN=4, MODE=1 and MODE=2. Each scenario task
//   checks only the instances it targets.

module tb_edge_detect_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_v = '0;
    logic [3:0] clr_v = '0;

    logic [3:0] d0_level, d0_pulse, d0_sticky;
    logic       d0_any;
    logic [3:0] f4_level, f4_pulse, f4_sticky;
    logic       f4_any;
    logic [3:0] m1_level, m1_pulse, m1_sticky;
    logic       m1_any;
    logic [3:0] m2_level, m2_pulse, m2_sticky;
    logic       m2_any;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    edge_detect_multi dut0 (
        .clk(clk), .rst(rst), .in(in_v), .clr(clr_v),
        .level(d0_level), .pulse(d0_pulse), .sticky(d0_sticky), .any_event(d0_any)
    );

    edge_detect_multi #(.FILTER_LEN(4)) dut_f4 (
        .clk(clk), .rst(rst), .in(in_v), .clr(clr_v),
        .level(f4_level), .pulse(f4_pulse), .sticky(f4_sticky), .any_event(f4_any)
    );

    edge_detect_multi #(.MODE(1)) dut_m1 (
        .clk(clk), .rst(rst), .in(in_v), .clr(clr_v),
        .level(m1_level), .pulse(m1_pulse), .sticky(m1_sticky), .any_event(m1_any)
    );

    edge_detect_multi #(.MODE(2)) dut_m2 (
        .clk(clk), .rst(rst), .in(in_v), .clr(clr_v),
        .level(m2_level), .pulse(m2_pulse), .sticky(m2_sticky), .any_event(m2_any)
    );

    // Advance one posedge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_v  = '0;
        clr_v = '0;
        rst   = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        in_v  = '0;
        clr_v = '0;
        rst   = 1'b1;
        #2;
        checks++;
        if (d0_level !== 4'h0) begin
            errors++; $display("FAIL reset_level got %h exp 0", d0_level);
        end
        checks++;
        if (d0_pulse !== 4'h0) begin
            errors++; $display("FAIL reset_pulse got %h exp 0", d0_pulse);
        end
        checks++;
        if (d0_sticky !== 4'h0) begin
            errors++; $display("FAIL reset_sticky got %h exp 0", d0_sticky);
        end
        checks++;
        if (d0_any !== 1'b0) begin
            errors++; $display("FAIL reset_any got %b exp 0", d0_any);
        end
        checks++;
        if ({f4_level, m1_level, m2_level} !== 12'h000) begin
            errors++; $display("FAIL reset_levels_other got %h exp 000", {f4_level, m1_level, m2_level});
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_rise_default();
        do_reset();
        in_v = 4'b0001;
        tick();
        tick();
        checks++;
        if (d0_level !== 4'h0) begin
            errors++; $display("FAIL rise_edge2_level got %h exp 0", d0_level);
        end
        tick();
        checks++;
        if (d0_level !== 4'b0001) begin
            errors++; $display("FAIL rise_edge3_level got %h exp 1", d0_level);
        end
        checks++;
        if (d0_pulse !== 4'b0001) begin
            errors++; $display("FAIL rise_edge3_pulse got %h exp 1", d0_pulse);
        end
        checks++;
        if (d0_sticky !== 4'b0001 || d0_any !== 1'b1) begin
            errors++; $display("FAIL rise_edge3_sticky got %h/%b exp 1/1", d0_sticky, d0_any);
        end
        tick();
        checks++;
        if (d0_pulse !== 4'h0) begin
            errors++; $display("FAIL rise_edge4_pulse got %h exp 0", d0_pulse);
        end
        checks++;
        if (d0_level !== 4'b0001 || d0_sticky !== 4'b0001) begin
            errors++; $display("FAIL rise_edge4_hold got %h/%h exp 1/1", d0_level, d0_sticky);
        end
    endtask

    task automatic test_filter();
        int npulse;
        do_reset();
        // Three-cycle glitch: one cycle short of qualifying.
        in_v[1] = 1'b1;
        tick();
        tick();
        tick();
        in_v[1] = 1'b0;
        npulse = 0;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (f4_pulse[1] === 1'b1) npulse++;
        end
        checks++;
        if (npulse !== 0 || f4_level[1] !== 1'b0) begin
            errors++; $display("FAIL filter_glitch pulses %0d level %b exp 0/0", npulse, f4_level[1]);
        end
        in_v[1] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 5) begin
                checks++;
                if (f4_level[1] !== 1'b0 || f4_pulse[1] !== 1'b0) begin
                    errors++; $display("FAIL filter_edge5 level %b pulse %b exp 0/0", f4_level[1], f4_pulse[1]);
                end
            end
            if (e == 6) begin
                checks++;
                if (f4_level[1] !== 1'b1 || f4_pulse !== 4'b0010) begin
                    errors++; $display("FAIL filter_edge6 level %b pulse %h exp 1/2", f4_level[1], f4_pulse);
                end
            end
            if (e == 7) begin
                checks++;
                if (f4_pulse[1] !== 1'b0) begin
                    errors++; $display("FAIL filter_edge7_pulse got %b exp 0", f4_pulse[1]);
                end
            end
        end
    endtask

    task automatic test_modes();
        int n0, n1, n2;
        do_reset();
        n0 = 0; n1 = 0; n2 = 0;
        in_v[2] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            n0 += int'(d0_pulse[2]);
            n1 += int'(m1_pulse[2]);
            n2 += int'(m2_pulse[2]);
            if (e == 3) begin
                checks++;
                if ({d0_pulse[2], m1_pulse[2], m2_pulse[2]} !== 3'b101) begin
                    errors++; $display("FAIL mode_rise d0/m1/m2 got %b exp 101", {d0_pulse[2], m1_pulse[2], m2_pulse[2]});
                end
            end
        end
        in_v[2] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            n0 += int'(d0_pulse[2]);
            n1 += int'(m1_pulse[2]);
            n2 += int'(m2_pulse[2]);
            if (e == 3) begin
                checks++;
                if ({d0_pulse[2], m1_pulse[2], m2_pulse[2]} !== 3'b011) begin
                    errors++; $display("FAIL mode_fall d0/m1/m2 got %b exp 011", {d0_pulse[2], m1_pulse[2], m2_pulse[2]});
                end
            end
        end
        checks++;
        if (n0 != 1 || n1 != 1 || n2 != 2) begin
            errors++; $display("FAIL mode_counts got %0d/%0d/%0d exp 1/1/2", n0, n1, n2);
        end
    endtask

    task automatic test_sticky_clr();
        do_reset();
        in_v[3] = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (d0_sticky !== 4'b1000 || d0_any !== 1'b1) begin
            errors++; $display("FAIL sticky_set got %h/%b exp 8/1", d0_sticky, d0_any);
        end
        in_v[3] = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (d0_level[3] !== 1'b0 || d0_sticky[3] !== 1'b1 || d0_pulse[3] !== 1'b0) begin
            errors++; $display("FAIL sticky_fall lvl %b st %b pl %b exp 0/1/0", d0_level[3], d0_sticky[3], d0_pulse[3]);
        end
        in_v[3] = 1'b1;
        tick(); tick();
        clr_v[3] = 1'b1;
        tick();
        checks++;
        if (d0_pulse[3] !== 1'b1 || d0_sticky[3] !== 1'b1) begin
            errors++; $display("FAIL sticky_set_wins pulse %b sticky %b exp 1/1", d0_pulse[3], d0_sticky[3]);
        end
        tick();
        checks++;
        if (d0_sticky !== 4'h0 || d0_any !== 1'b0) begin
            errors++; $display("FAIL sticky_clear got %h/%b exp 0/0", d0_sticky, d0_any);
        end
        tick();
        checks++;
        if (d0_sticky !== 4'h0 || d0_level[3] !== 1'b1) begin
            errors++; $display("FAIL sticky_clr_zero st %h lvl %b exp 0/1", d0_sticky, d0_level[3]);
        end
        clr_v = '0;
    endtask

    task automatic test_all_channels();
        do_reset();
        in_v = 4'hF;
        tick(); tick();
        checks++;
        if (d0_pulse !== 4'h0) begin
            errors++; $display("FAIL all_edge2_pulse got %h exp 0", d0_pulse);
        end
        tick();
        checks++;
        if (d0_pulse !== 4'hF || d0_level !== 4'hF) begin
            errors++; $display("FAIL all_edge3 pulse %h level %h exp F/F", d0_pulse, d0_level);
        end
        checks++;
        if (d0_sticky !== 4'hF || d0_any !== 1'b1) begin
            errors++; $display("FAIL all_edge3_sticky got %h/%b exp F/1", d0_sticky, d0_any);
        end
        tick();
        checks++;
        if (d0_pulse !== 4'h0 || d0_sticky !== 4'hF) begin
            errors++; $display("FAIL all_edge4 pulse %h sticky %h exp 0/F", d0_pulse, d0_sticky);
        end
    endtask

    task automatic test_reset_midflight();
        int npulse;
        // Falling edge enters the synchroniser, then reset lands mid-cycle.
        in_v = 4'h0;
        tick();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (d0_level !== 4'h0 || d0_pulse !== 4'h0 || d0_sticky !== 4'h0 || d0_any !== 1'b0) begin
            errors++; $display("FAIL midrst_async got %h/%h/%h/%b exp 0/0/0/0", d0_level, d0_pulse, d0_sticky, d0_any);
        end
        in_v = 4'b0001;
        tick();
        tick();
        rst = 1'b0;
        npulse = 0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            npulse += int'(d0_pulse[0]);
            if (e == 2) begin
                checks++;
                if (d0_level !== 4'h0) begin
                    errors++; $display("FAIL midrst_edge2_level got %h exp 0", d0_level);
                end
            end
            if (e == 3) begin
                checks++;
                if (d0_pulse !== 4'b0001 || d0_level !== 4'b0001) begin
                    errors++; $display("FAIL midrst_edge3 pulse %h level %h exp 1/1", d0_pulse, d0_level);
                end
            end
        end
        checks++;
        if (npulse != 1) begin
            errors++; $display("FAIL midrst_pulse_count got %0d exp 1", npulse);
        end
    endtask

    initial begin
        test_reset();
        test_rise_default();
        test_filter();
        test_modes();
        test_sticky_clr();
        test_all_channels();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
